// File: rtl/attempt_guard.sv
// Digit-lock sequencing controller: stores the master code, checks submissions,
// counts consecutive failures and enforces a tick-timed lockout.
module attempt_guard #(
    parameter int unsigned MAX_FAILS     = 3,
    parameter int unsigned LOCKOUT_TICKS = 30,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             clk,
    input  logic             master_rst,
    input  logic             tick,
    input  logic             submit,
    input  logic             arm,
    input  logic             change,
    input  logic             clear,
    input  logic [15:0]      entered_code,
    output logic             lock_rst,
    output logic [1:0]       status,
    output logic [3:0]       fails,
    output logic [CNT_W-1:0] remaining,
    output logic             accept,
    output logic             reject
);

    typedef enum logic [1:0] {
        ST_INIT     = 2'b00,
        ST_LOCKED   = 2'b01,
        ST_UNLOCKED = 2'b10,
        ST_LOCKOUT  = 2'b11
    } state_e;

    localparam logic [3:0]       MaxFails = 4'(MAX_FAILS);
    localparam logic [CNT_W-1:0] Ticks    = CNT_W'(LOCKOUT_TICKS);
    localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

    state_e           state_q, state_d;
    logic [15:0]      code_q, code_d;
    logic [3:0]       fails_q, fails_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             accept_q, accept_d;
    logic             reject_q, reject_d;
    logic             lock_rst_q, lock_rst_d;
    logic             submit_q, arm_q;

    logic sub_p, arm_p, match;

    assign sub_p = submit & ~submit_q;
    assign arm_p = arm & ~arm_q;
    assign match = (entered_code == code_q);

    always_ff @(posedge clk or negedge master_rst) begin
        if (!master_rst) begin
            state_q    <= ST_INIT;
            code_q     <= 16'h0000;
            fails_q    <= 4'd0;
            rem_q      <= '0;
            accept_q   <= 1'b0;
            reject_q   <= 1'b0;
            lock_rst_q <= 1'b1;
            submit_q   <= 1'b0;
            arm_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            fails_q    <= fails_d;
            rem_q      <= rem_d;
            accept_q   <= accept_d;
            reject_q   <= reject_d;
            lock_rst_q <= lock_rst_d;
            submit_q   <= submit;
            arm_q      <= arm;
        end
    end

    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        fails_d    = fails_q;
        rem_d      = rem_q;
        accept_d   = 1'b0;
        reject_d   = 1'b0;
        lock_rst_d = lock_rst_q;

        unique case (state_q)
            ST_INIT: begin
                lock_rst_d = clear;
                if (arm_p) begin
                    code_d     = entered_code;
                    lock_rst_d = 1'b1;
                    fails_d    = 4'd0;
                    state_d    = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                lock_rst_d = clear;
                // A submission always flushes the entry datapath, even over clear
                if (sub_p) begin
                    lock_rst_d = 1'b1;
                    if (match) begin
                        accept_d = 1'b1;
                        fails_d  = 4'd0;
                        state_d  = ST_UNLOCKED;
                    end else begin
                        reject_d = 1'b1;
                        if (fails_q + 4'd1 == MaxFails) begin
                            fails_d = MaxFails;
                            rem_d   = Ticks;
                            state_d = ST_LOCKOUT;
                        end else begin
                            fails_d = fails_q + 4'd1;
                        end
                    end
                end
            end
            ST_LOCKOUT: begin
                lock_rst_d = 1'b1;
                if (tick) begin
                    if (rem_q > CntOne) begin
                        rem_d = rem_q - CntOne;
                    end else begin
                        rem_d      = '0;
                        fails_d    = 4'd0;
                        lock_rst_d = 1'b0;
                        state_d    = ST_LOCKED;
                    end
                end
            end
            ST_UNLOCKED: begin
                lock_rst_d = 1'b0;
                if (change) begin
                    lock_rst_d = 1'b1;
                    state_d    = ST_INIT;
                end else if (arm_p) begin
                    lock_rst_d = 1'b1;
                    fails_d    = 4'd0;
                    state_d    = ST_LOCKED;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    assign status    = state_q;
    assign lock_rst  = lock_rst_q;
    assign fails     = fails_q;
    assign remaining = rem_q;
    assign accept    = accept_q;
    assign reject    = reject_q;

endmodule

// File: tb/tb_attempt_guard.sv
// Bench for attempt_guard: a rule-level model checked every cycle plus
// hand-computed expectations for the directed scenarios.
module tb_attempt_guard;

    localparam int MF = 3;
    localparam int LT = 4;
    localparam int CW = 8;

    localparam int M_INIT = 0;
    localparam int M_LOCKED = 1;
    localparam int M_UNLOCKED = 2;
    localparam int M_LOCKOUT = 3;

    logic          clk = 1'b0;
    logic          master_rst = 1'b0;
    logic          tick = 1'b0;
    logic          submit = 1'b0;
    logic          arm = 1'b0;
    logic          change = 1'b0;
    logic          clear = 1'b0;
    logic [15:0]   entered_code = 16'h0000;
    logic          lock_rst;
    logic [1:0]    status;
    logic [3:0]    fails;
    logic [CW-1:0] remaining;
    logic          accept;
    logic          reject;

    int checks = 0;
    int failures = 0;

    // rule-level expectation
    int m_mode = M_INIT;
    int m_code = 0;
    int m_fails = 0;
    int m_left = 0;
    int m_acc = 0;
    int m_rej = 0;
    int m_lrst = 1;
    int m_psub = 0;
    int m_parm = 0;

    attempt_guard #(
        .MAX_FAILS(MF),
        .LOCKOUT_TICKS(LT),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .master_rst(master_rst),
        .tick(tick),
        .submit(submit),
        .arm(arm),
        .change(change),
        .clear(clear),
        .entered_code(entered_code),
        .lock_rst(lock_rst),
        .status(status),
        .fails(fails),
        .remaining(remaining),
        .accept(accept),
        .reject(reject)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_INIT;
        m_code = 0;
        m_fails = 0;
        m_left = 0;
        m_acc = 0;
        m_rej = 0;
        m_lrst = 1;
        m_psub = 0;
        m_parm = 0;
    endtask

    task automatic model_step();
        bit new_sub, new_arm;
        new_sub = submit && (m_psub == 0);
        new_arm = arm && (m_parm == 0);
        m_psub = int'(submit);
        m_parm = int'(arm);
        m_acc = 0;
        m_rej = 0;
        if (m_mode == M_INIT) begin
            m_lrst = int'(clear);
            if (new_arm) begin
                m_code = int'(entered_code);
                m_lrst = 1;
                m_fails = 0;
                m_mode = M_LOCKED;
            end
        end else if (m_mode == M_LOCKED) begin
            m_lrst = int'(clear);
            if (new_sub && int'(entered_code) == m_code) begin
                m_acc = 1;
                m_lrst = 1;
                m_fails = 0;
                m_mode = M_UNLOCKED;
            end else if (new_sub) begin
                m_rej = 1;
                m_lrst = 1;
                m_fails = m_fails + 1;
                if (m_fails == MF) begin
                    m_left = LT;
                    m_mode = M_LOCKOUT;
                end
            end
        end else if (m_mode == M_LOCKOUT) begin
            m_lrst = 1;
            if (tick) m_left = m_left - 1;
            if (m_left == 0) begin
                m_fails = 0;
                m_lrst = 0;
                m_mode = M_LOCKED;
            end
        end else begin
            m_lrst = 0;
            if (change) begin
                m_lrst = 1;
                m_mode = M_INIT;
            end else if (new_arm) begin
                m_lrst = 1;
                m_fails = 0;
                m_mode = M_LOCKED;
            end
        end
    endtask

    always @(posedge clk or negedge master_rst) begin
        if (!master_rst) model_reset();
        else model_step();
    end

    always @(negedge clk) begin
        chk("status", int'(status), m_mode);
        chk("lock_rst", int'(lock_rst), m_lrst);
        chk("fails", int'(fails), m_fails);
        chk("remaining", int'(remaining), m_left);
        chk("accept", int'(accept), m_acc);
        chk("reject", int'(reject), m_rej);
    end

    // drive one cycle of inputs; returns just after the next falling edge
    task automatic step(input logic s, input logic a, input logic ch,
                        input logic cl, input logic tk, input logic [15:0] c);
        submit = s;
        arm = a;
        change = ch;
        clear = cl;
        tick = tk;
        entered_code = c;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input logic [15:0] c);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, c);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk("rst_status", int'(status), 0);
        chk("rst_lock_rst", int'(lock_rst), 1);
        chk("rst_remaining", int'(remaining), 0);
        master_rst = 1'b1;

        // set and unlock
        idle(16'h1234);
        chk("init_lrst", int'(lock_rst), 0);
        step(0, 0, 0, 1, 0, 16'h1234);
        chk("init_clear", int'(lock_rst), 1);
        step(0, 1, 0, 0, 0, 16'h1234);
        chk("arm_status", int'(status), 1);
        chk("arm_lrst", int'(lock_rst), 1);
        idle(16'h1234);
        chk("arm_lrst_drop", int'(lock_rst), 0);
        step(1, 0, 0, 0, 0, 16'h1234);
        chk("unlock_acc", int'(accept), 1);
        chk("unlock_status", int'(status), 2);
        idle(16'h1234);
        chk("acc_width", int'(accept), 0);

        // arm alone relocks
        step(0, 1, 0, 0, 0, 16'h1234);
        chk("relock_status", int'(status), 1);
        idle(16'h1234);

        // three wrong codes into lockout
        for (int i = 1; i <= 3; i++) begin
            step(1, 0, 0, 0, 0, 16'h1111);
            chk("wrong_rej", int'(reject), 1);
            chk("wrong_fails", int'(fails), i);
            idle(16'h1111);
        end
        chk("lo_status", int'(status), 3);
        chk("lo_rem", int'(remaining), 4);

        // lockout immunity
        step(1, 1, 1, 1, 0, 16'h1234);
        chk("imm_acc", int'(accept), 0);
        chk("imm_status", int'(status), 3);
        step(0, 0, 0, 0, 1, 16'h1234);
        chk("tick1_rem", int'(remaining), 3);
        step(1, 0, 1, 1, 0, 16'h1234);
        chk("imm_rem", int'(remaining), 3);
        step(0, 0, 0, 0, 1, 16'h1234);
        step(0, 0, 0, 0, 1, 16'h1234);
        chk("tick3_rem", int'(remaining), 1);
        step(0, 0, 0, 0, 1, 16'h1234);
        chk("exit_status", int'(status), 1);
        chk("exit_fails", int'(fails), 0);
        chk("exit_lrst", int'(lock_rst), 0);
        chk("exit_rem", int'(remaining), 0);

        // held submit yields one pulse
        repeat (10) step(1, 0, 0, 0, 0, 16'h1111);
        chk("held_fails", int'(fails), 1);
        idle(16'h1111);
        step(1, 0, 0, 1, 0, 16'h1111);
        chk("subclr_rej", int'(reject), 1);
        chk("subclr_lrst", int'(lock_rst), 1);
        chk("subclr_fails", int'(fails), 2);
        idle(16'h1111);

        // tick on the entry edge is not counted
        step(1, 0, 0, 0, 1, 16'h1111);
        chk("entry_rem", int'(remaining), 4);
        step(0, 0, 0, 0, 1, 16'h1111);
        chk("entry_next", int'(remaining), 3);
        step(0, 0, 0, 0, 1, 16'h1111);
        chk("pre_rst_rem", int'(remaining), 2);

        // async reset between edges
        #2;
        master_rst = 1'b0;
        #1;
        chk("async_status", int'(status), 0);
        chk("async_lrst", int'(lock_rst), 1);
        chk("async_fails", int'(fails), 0);
        chk("async_rem", int'(remaining), 0);
        @(negedge clk);
        #1;
        master_rst = 1'b1;
        step(1, 0, 0, 0, 0, 16'h0000);
        chk("init_sub_acc", int'(accept), 0);
        chk("init_sub_status", int'(status), 0);
        idle(16'h0000);

        // unlocked exits and a new code
        step(0, 1, 0, 0, 0, 16'h1234);
        idle(16'h1234);
        step(1, 0, 0, 0, 0, 16'h1234);
        chk("re_unlock", int'(status), 2);
        idle(16'h1234);
        step(0, 1, 1, 0, 0, 16'h1234);
        chk("chg_prio", int'(status), 0);
        idle(16'h9876);
        step(0, 1, 0, 0, 0, 16'h9876);
        chk("new_code", int'(status), 1);
        idle(16'h1234);
        step(1, 0, 0, 0, 0, 16'h1234);
        chk("old_rej", int'(reject), 1);
        idle(16'h9876);
        step(1, 0, 0, 0, 0, 16'h9876);
        chk("new_acc", int'(accept), 1);
        idle(16'h9876);
        idle(16'h9876);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/attempt_guard.md
# attempt_guard

Sequencing controller for the digit-lock entry datapath. Owns the lock state (initial / locked / unlocked / lockout), stores the master code, compares submitted codes, and drives the entry datapath's reset. Rate-limits brute-force entry with a failed-attempt counter and a timed lockout. Sits between the debounced buttons and the entry datapath, on the same slow clock; its `status` output feeds the status segment decoder.

## Interface
- `MAX_FAILS`, default 3: consecutive wrong submissions that trigger lockout. Legal range 1..15.
- `LOCKOUT_TICKS`, default 30: lockout duration in `tick` strobes. Must be ≥1 and < 2^CNT_W.
- `CNT_W`, default 8: width of the lockout countdown.
- `clk` in 1: slow system clock; all state is updated on its rising edge.
- `master_rst` in 1: asynchronous, active-low reset (0 = reset).
- `tick` in 1: single-cycle timebase strobe used only by the lockout countdown.
- `submit` in 1: debounced level; a rising edge is one code submission.
- `arm` in 1: debounced level; a rising edge is a set/lock request.
- `change` in 1: level; in UNLOCKED it returns the block to INIT.
- `clear` in 1: level; requests an entry-datapath reset.
- `entered_code` in 16: four BCD digits from the entry datapath, with `[15:12]` as the most significant digit.
- `lock_rst` out 1: reset to the entry datapath (1 = hold in reset).
- `status` out 2: 00 INIT, 01 LOCKED, 10 UNLOCKED, 11 LOCKOUT.
- `fails` out 4: current consecutive failure count.
- `remaining` out CNT_W: lockout ticks remaining; 0 outside LOCKOUT.
- `accept` out 1: one-cycle pulse on a correct submission.
- `reject` out 1: one-cycle pulse on a wrong submission.

## Operation
- **Reset values** (while `master_rst`=0):
  - status=00, lock_rst=1.
  - fails=0, remaining=0, accept=0, reject=0.
  - Stored code = 16'h0000; edge-detect flops = 0.
- **Edge detection:**
  - sub_p = submit & ~submit_q; arm_p = arm & ~arm_q.
  - submit_q and arm_q register every cycle in all states.
  - A level held high produces exactly one pulse.
- **accept / reject** default to 0 every cycle; they are asserted only as described below.
- **INIT:**
  - lock_rst <= clear.
  - On arm_p: stored code <= entered_code, lock_rst <= 1, fails <= 0, status -> LOCKED.
  - sub_p and change are ignored.
- **LOCKED:**
  - Default: lock_rst <= clear.
  - On sub_p with entered_code == stored code:
    - accept <= 1, fails <= 0, lock_rst <= 1, status -> UNLOCKED.
  - On sub_p with a mismatch:
    - reject <= 1, lock_rst <= 1.
    - If fails+1 == MAX_FAILS: fails <= MAX_FAILS, remaining <= LOCKOUT_TICKS, status -> LOCKOUT.
    - Otherwise fails <= fails+1.
  - sub_p takes priority over clear when both occur in the same cycle; lock_rst is 1 either way.
  - arm_p is ignored.
- **LOCKOUT:**
  - lock_rst held at 1; sub_p, arm_p, change and clear are all ignored (no reject pulse).
  - On tick with remaining > 1: remaining <= remaining-1.
  - On tick with remaining == 1: remaining <= 0, fails <= 0, lock_rst <= 0, status -> LOCKED.
- **UNLOCKED:**
  - Default: lock_rst <= 0.
  - change=1: lock_rst <= 1, status -> INIT. The stored code is retained until the next arm_p in INIT.
  - Else on arm_p: lock_rst <= 1, status -> LOCKED, fails <= 0.
  - change has priority over arm_p.
- **Comparison:** full 16-bit equality. No wildcard or partial matching.
- **Unused status encoding:** none; all four encodings are legal states.

## Timing
- All outputs are registered.
- Latency is one clock. An edge sampled at rising edge N changes status/accept/reject/lock_rst as seen after edge N.
- accept and reject are exactly one cycle wide and never asserted together.
- `tick` is sampled only in LOCKOUT.
  - A tick coincident with the entry cycle into LOCKOUT does not decrement.
  - The LOCKOUT dwell is LOCKOUT_TICKS ticks after entry.
- Reset is asynchronous on assertion. Asserting it mid-lockout or mid-unlock forces every reset value immediately, including clearing the stored code.
- Deassertion is assumed synchronous to `clk` (synchronized upstream). The first active edge after release evaluates INIT.
- Inputs are assumed already debounced and synchronous to `clk`.

## Test plan
- **Set and unlock:** reset; entered_code=16'h1234, pulse arm -> status=01, lock_rst=1 for one cycle. Then submit with 16'h1234 -> accept pulse, status=10, fails=0.
- **Wrong codes into lockout** (MAX_FAILS=3, LOCKOUT_TICKS=4): store 16'h1234; submit 16'h1111 three times -> reject ×3, fails 1,2,3, status=11, remaining=4. Apply 4 ticks -> remaining 3,2,1,0, status=01, fails=0, lock_rst=0.
- **Lockout immunity:** in LOCKOUT, submit the correct code and toggle arm/change/clear -> no accept/reject, status stays 11, remaining changes only on tick.
- **Edge semantics:** hold submit high for 10 cycles with a wrong code -> exactly one reject, fails=1. Submit and clear in the same cycle -> reject asserted, lock_rst=1.
- **Unlocked exits:**
  - From 10, change=1 and arm rising in the same cycle -> status=00.
  - From 10, arm alone -> status=01.
  - From 00, arm with 16'h9876 -> new code stored; the old code is then rejected.
- **Async reset mid-operation:** in LOCKOUT with remaining=2, drive master_rst=0 between clock edges -> status=00, lock_rst=1, fails=0, remaining=0 immediately. After release, submitting 16'h0000 in INIT -> no accept.
